// File: rtl/sam_arith_sequencer_if.sv
// Bundle between the SAM arithmetic sequencer and its surroundings: opcode handshake,
// register-file read/write ports, arithmetic-unit drive/result and status outputs.
interface sam_arith_sequencer_if #(
  parameter int unsigned TGT_BITS = 32,
  parameter int unsigned REG_BITS = 3
);
  logic                opValid;
  logic [15:0]         opcode;
  logic                opReady;
  logic [REG_BITS-1:0] rdAddrL;
  logic [REG_BITS-1:0] rdAddrR;
  logic [TGT_BITS-1:0] rdDataL;
  logic [TGT_BITS-1:0] rdDataR;
  logic                aluGo;
  logic [4:0]          aluSubOp;
  logic [TGT_BITS-1:0] aluLeft;
  logic [TGT_BITS-1:0] aluRite;
  logic [TGT_BITS:0]   aluWord;
  logic                aluCarry;
  logic                wrEn;
  logic [REG_BITS-1:0] wrAddr;
  logic [TGT_BITS-1:0] wrData;
  logic                carryF;
  logic                zeroF;
  logic                done;
  logic                errPulse;

  modport master (
    input  opValid, opcode, rdDataL, rdDataR, aluWord, aluCarry,
    output opReady, rdAddrL, rdAddrR, aluGo, aluSubOp, aluLeft, aluRite,
           wrEn, wrAddr, wrData, carryF, zeroF, done, errPulse
  );

  modport slave (
    output opValid, opcode, rdDataL, rdDataR, aluWord, aluCarry,
    input  opReady, rdAddrL, rdAddrR, aluGo, aluSubOp, aluLeft, aluRite,
           wrEn, wrAddr, wrData, carryF, zeroF, done, errPulse
  );
endinterface

// File: rtl/sam_arith_sequencer.sv
// Initiator side of the SAM arithmetic unit: accepts one opcode, issues it to the unit,
// captures the one-cycle-late result, writes it back and updates carry/zero flags.
module sam_arith_sequencer #(
  parameter int unsigned TGT_BITS = 32,
  parameter int unsigned REG_BITS = 3,
  parameter logic [4:0]  OPS_CMP  = 5'd4
) (
  input logic                   clk,
  input logic                   rsta,
  sam_arith_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StWrite} state_e;

  state_e              state_q, state_d;
  logic [REG_BITS-1:0] dreg_q, dreg_d;
  logic [4:0]          sub_op_q, sub_op_d;
  logic [TGT_BITS-1:0] left_q, left_d;
  logic [TGT_BITS-1:0] rite_q, rite_d;
  logic [TGT_BITS-1:0] wr_data_q, wr_data_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic                op_legal;
  logic                unused_word_msb;

  // Bit TGT_BITS of the unit result only reaches the flags through aluCarry.
  assign unused_word_msb = bus.aluWord[TGT_BITS];

  assign op_legal    = (bus.opcode[4:0] == 5'b11000) && !bus.opcode[12];
  assign bus.rdAddrL = REG_BITS'(bus.opcode[15:13]);
  assign bus.rdAddrR = REG_BITS'(bus.opcode[7:5]);

  always_comb begin
    state_d   = state_q;
    dreg_d    = dreg_q;
    sub_op_d  = sub_op_q;
    left_d    = left_q;
    rite_d    = rite_q;
    wr_data_d = wr_data_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.opValid) begin
          if (op_legal) begin
            state_d  = StIssue;
            dreg_d   = REG_BITS'(bus.opcode[15:13]);
            sub_op_d = bus.opcode[12:8];
            left_d   = bus.rdDataL;
            rite_d   = bus.rdDataR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StCapture;
      // Operands stay put here: aluCarry is combinational on subOp and rite.
      StCapture: begin
        wr_data_d = bus.aluWord[TGT_BITS-1:0];
        carry_d   = bus.aluCarry;
        zero_d    = (bus.aluWord[TGT_BITS-1:0] == '0);
        state_d   = StWrite;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      state_q   <= StIdle;
      dreg_q    <= '0;
      sub_op_q  <= '0;
      left_q    <= '0;
      rite_q    <= '0;
      wr_data_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dreg_q    <= dreg_d;
      sub_op_q  <= sub_op_d;
      left_q    <= left_d;
      rite_q    <= rite_d;
      wr_data_q <= wr_data_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign bus.opReady  = (state_q == StIdle);
  assign bus.aluGo    = (state_q == StIssue);
  assign bus.aluSubOp = sub_op_q;
  assign bus.aluLeft  = left_q;
  assign bus.aluRite  = rite_q;
  assign bus.wrEn     = (state_q == StWrite) && (sub_op_q != OPS_CMP);
  assign bus.wrAddr   = dreg_q;
  assign bus.wrData   = wr_data_q;
  assign bus.carryF   = carry_q;
  assign bus.zeroF    = zero_q;
  assign bus.done     = (state_q == StWrite) || err_q;
  assign bus.errPulse = err_q;

endmodule

// File: tb/tb_sam_arith_sequencer.sv
// Scoreboard bench for sam_arith_sequencer: a behavioural arithmetic-unit stub and register
// file surround the DUT; expected write-backs/flags are queued at accept and checked on done.
`timescale 1ns/1ps
module tb_sam_arith_sequencer;
  localparam int unsigned TGT_BITS = 32;
  localparam int unsigned REG_BITS = 3;
  localparam logic [4:0] OPS_ADD = 5'd0;
  localparam logic [4:0] OPS_SUB = 5'd2;
  localparam logic [4:0] OPS_CMP = 5'd4;
  localparam logic [4:0] OPS_SHR = 5'd13;
  localparam logic [4:0] TAIL    = 5'b11000;

  typedef struct {
    bit          legal;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    bit          c;
    bit          z;
    logic [4:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    int unsigned go_cyc;
    int unsigned done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rsta = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          model_c = 1'b0;
  bit          model_z = 1'b0;
  logic [31:0] regs [8];
  logic [32:0] alu_q;
  logic [4:0]  op_tab [4] = '{OPS_ADD, OPS_SUB, OPS_CMP, OPS_SHR};

  sam_arith_sequencer_if #(.TGT_BITS(TGT_BITS), .REG_BITS(REG_BITS)) bus ();

  sam_arith_sequencer #(.TGT_BITS(TGT_BITS), .REG_BITS(REG_BITS), .OPS_CMP(OPS_CMP)) dut (
    .clk (clk),
    .rsta(rsta),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: {carry, word} for the subOps this bench exercises.
  function automatic logic [32:0] alu_ref(input logic [4:0] op, input logic [31:0] l,
                                          input logic [31:0] r);
    case (op)
      OPS_ADD:          return {1'b0, l} + {1'b0, r};
      OPS_SUB, OPS_CMP: return {1'b0, l} - {1'b0, r};
      OPS_SHR:          return {r[0], 1'b0, r[31:1]};
      default:          return '0;
    endcase
  endfunction

  assign bus.rdDataL  = regs[bus.rdAddrL];
  assign bus.rdDataR  = regs[bus.rdAddrR];
  assign bus.aluWord  = alu_q;
  assign bus.aluCarry = (bus.aluSubOp == OPS_SHR) ? bus.aluRite[0] : alu_q[32];

  always @(posedge clk or posedge rsta) begin
    if (rsta) alu_q <= '0;
    else if (bus.aluGo) alu_q <= alu_ref(bus.aluSubOp, bus.aluLeft, bus.aluRite);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse and watches issue/capture cycles.
  always @(negedge clk) begin
    if (!rsta) begin
      if (bus.aluGo) begin
        if (exp_q.size() == 0 || !exp_q[0].legal) check("spurious_go", bus.aluGo, 0);
        else begin
          check("go_cycle", 64'(cyc), 64'(exp_q[0].go_cyc));
          check("go_subop", bus.aluSubOp, exp_q[0].op);
          check("go_left", bus.aluLeft, exp_q[0].l);
          check("go_rite", bus.aluRite, exp_q[0].r);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].legal && cyc == exp_q[0].go_cyc + 1) begin
        check("capture_go_low", bus.aluGo, 0);
        check("capture_subop_hold", bus.aluSubOp, exp_q[0].op);
        check("capture_left_hold", bus.aluLeft, exp_q[0].l);
        check("capture_rite_hold", bus.aluRite, exp_q[0].r);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) check("spurious_done", bus.done, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          check("err_pulse", bus.errPulse, !mon_e.legal);
          check("wr_en", bus.wrEn, mon_e.wr);
          if (mon_e.wr) begin
            check("wr_addr", bus.wrAddr, mon_e.addr);
            check("wr_data", bus.wrData, mon_e.data);
          end
          check("carry_flag", bus.carryF, mon_e.c);
          check("zero_flag", bus.zeroF, mon_e.z);
        end
      end else if (bus.wrEn || bus.errPulse) begin
        check("strobe_without_done", {bus.wrEn, bus.errPulse}, 0);
      end
    end
  end

  task automatic issue(input logic [2:0] d, input logic [4:0] op, input logic [2:0] s,
                       input logic [4:0] tail);
    exp_t        e;
    logic [32:0] res;
    int unsigned guard = 0;
    @(negedge clk);
    bus.opValid = 1'b1;
    bus.opcode  = {d, op, s, tail};
    while (!bus.opReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.opReady, 1);
    e.legal    = (tail == TAIL) && !op[4];
    e.op       = op;
    e.l        = regs[d];
    e.r        = regs[s];
    e.addr     = d;
    e.go_cyc   = cyc + 1;
    e.done_cyc = e.legal ? cyc + 3 : cyc + 1;
    if (e.legal) begin
      res     = alu_ref(op, regs[d], regs[s]);
      e.data  = res[31:0];
      e.c     = res[32];
      e.z     = (res[31:0] == 32'd0);
      e.wr    = (op != OPS_CMP);
      model_c = e.c;
      model_z = e.z;
    end else begin
      e.data = '0;
      e.c    = model_c;
      e.z    = model_z;
      e.wr   = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.opValid = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_go", bus.aluGo, 0);
    check("rst_wr_en", bus.wrEn, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.errPulse, 0);
    check("rst_flags", {bus.carryF, bus.zeroF}, 0);
    check("rst_subop", bus.aluSubOp, 0);
    check("rst_left", bus.aluLeft, 0);
    check("rst_rite", bus.aluRite, 0);
    check("rst_wr_addr", bus.wrAddr, 0);
    check("rst_wr_data", bus.wrData, 0);
    check("rst_ready", bus.opReady, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish by 100000ns");
    $fatal(1, "timeout");
  end

  initial begin
    bus.opValid = 1'b0;
    bus.opcode  = '0;
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rsta = 1'b0;

    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(3'd1, OPS_ADD, 3'd2, TAIL); drain();
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
    issue(3'd1, OPS_ADD, 3'd2, TAIL); drain();
    regs[4] = 32'd3;
    issue(3'd3, OPS_SHR, 3'd4, TAIL); drain();
    regs[1] = 32'd9; regs[2] = 32'd9;
    issue(3'd1, OPS_CMP, 3'd2, TAIL); drain();

    issue(3'd1, OPS_ADD, 3'd2, 5'b11001);
    check("illegal_ready_held", bus.opReady, 1);
    drain();
    issue(3'd2, 5'b10011, 3'd5, TAIL);
    check("illegal_ready_held2", bus.opReady, 1);
    drain();

    // A second offer during ISSUE/CAPTURE must be ignored.
    regs[6] = $urandom; regs[7] = $urandom;
    issue(3'd6, OPS_SUB, 3'd7, TAIL);
    bus.opValid = 1'b1;
    bus.opcode  = {3'd0, OPS_ADD, 3'd1, TAIL};
    @(negedge clk);
    @(negedge clk);
    bus.opValid = 1'b0;
    drain();

    // Asynchronous reset during CAPTURE abandons the op.
    regs[2] = 32'h1234_5678; regs[3] = 32'h1111_1111;
    issue(3'd2, OPS_ADD, 3'd3, TAIL);
    @(negedge clk);
    @(negedge clk);
    #2 rsta = 1'b1;
    #1 check_reset_outputs();
    exp_q.delete();
    model_c = 1'b0;
    model_z = 1'b0;
    @(negedge clk);
    rsta = 1'b0;
    repeat (3) @(negedge clk);
    regs[5] = 32'd40; regs[0] = 32'd2;
    issue(3'd5, OPS_SUB, 3'd0, TAIL); drain();

    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      logic [4:0] tail;
      int unsigned pick;
      for (int i = 0; i < 8; i++) begin
        pick    = $urandom_range(0, 9);
        regs[i] = (pick == 0) ? 32'd0 : (pick == 1) ? 32'hFFFF_FFFF : $urandom;
      end
      op   = op_tab[$urandom_range(0, 3)];
      tail = TAIL;
      pick = $urandom_range(0, 9);
      if (pick == 0) tail = TAIL ^ 5'($urandom_range(1, 31));
      else if (pick == 1) op = op | 5'b10000;
      issue(3'($urandom_range(0, 7)), op, 3'($urandom_range(0, 7)), tail);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sam_arith_sequencer.md
Name: sam_arith_sequencer

Overview:
Initiator side of the SAM arithmetic-unit interface. It accepts one arithmetic opcode at a time, decodes the dreg/subOp/sreg fields, and reads the register file. It then drives the arithmetic unit's go/subOp/left/rite inputs, captures the one-cycle-late wordO/carryO result, writes the result back to $dreg, and updates the carry and zero flags. It sits between the instruction fetch/dispatch logic and the arithmetic unit.

Parameters:
TGT_BITS, 32, datapath word width; must match the arithmetic unit.
REG_BITS, 3, register-select width; 8 registers.

Ports:
clk  in  1  clock, all logic on posedge
rsta  in  1  reset, asynchronous, active-high
opValid  in  1  opcode offered
opcode  in  16  [15:13]=dreg, [12:8]=subOp, [7:5]=sreg, [4:0]=5'b11000
opReady  out  1  sequencer can accept; high only in IDLE
rdAddrL  out  REG_BITS  register-file read address, left operand
rdAddrR  out  REG_BITS  register-file read address, rite operand
rdDataL  in  TGT_BITS  combinational read data for rdAddrL
rdDataR  in  TGT_BITS  combinational read data for rdAddrR
aluGo  out  1  one-cycle go to the arithmetic unit
aluSubOp  out  5  subOp to the arithmetic unit
aluLeft  out  TGT_BITS  left operand
aluRite  out  TGT_BITS  rite operand
aluWord  in  TGT_BITS+1  wordO from the arithmetic unit
aluCarry  in  1  carryO from the arithmetic unit
wrEn  out  1  register write strobe
wrAddr  out  REG_BITS  write register
wrData  out  TGT_BITS  write data
carryF  out  1  carry flag
zeroF  out  1  zero flag
done  out  1  one-cycle completion pulse
errPulse  out  1  one-cycle illegal-opcode pulse

Behaviour:
- Reset (rsta asserted, asynchronous): state=IDLE; aluGo, wrEn, done, errPulse, carryF, zeroF = 0; aluSubOp, aluLeft, aluRite, wrAddr, wrData = 0.
- Reset mid-operation: any in-flight op is abandoned with no wrEn and no done.
- Read addresses: rdAddrL = opcode[15:13] (dreg); rdAddrR = opcode[7:5] (sreg). Both are driven combinationally from opcode while in IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, WRITE.
- IDLE: opReady=1. On opValid, latch opcode fields and rdDataL/rdDataR.
  - Legal opcode (opcode[4:0]==5'b11000 and subOp[4]==0): go to ISSUE.
  - Otherwise: errPulse=1 and done=1 next cycle, no aluGo, no flag change, stay in IDLE.
- ISSUE: aluGo=1 for exactly one cycle; aluSubOp, aluLeft, aluRite present the latched values. Next state: CAPTURE.
- CAPTURE: aluGo=0.
  - aluSubOp, aluRite and aluLeft stay unchanged, because aluCarry depends combinationally on subOp and rite.
  - Sample aluWord[TGT_BITS-1:0] into wrData.
  - carryF <= aluCarry; zeroF <= (aluWord[TGT_BITS-1:0]==0).
  - Next state: WRITE.
- WRITE: done=1.
  - wrEn=1 with wrAddr=dreg, except when subOp==OPS_CMP: no write, flags only.
  - Next state: IDLE.
- Latency: accept at cycle T, aluGo at T+1, flags valid at T+3, wrEn/done at T+3. Throughput is one op per 4 cycles.
- Unary subOps (OPS_INC..OPS_RCR): aluLeft is still driven with rdDataL and is ignored by the arithmetic unit.
- Width rule: the arithmetic unit's extra bit aluWord[TGT_BITS] is never written to the register file; it affects only carryF, via aluCarry.
- The ALU carry chain (ADC/SBB/RCL/RCR) is kept inside the arithmetic unit. carryF is a visible copy only; the sequencer never feeds it back.
- opValid while not in IDLE is ignored (opReady=0). The source must hold the opcode until accepted.
- dreg==sreg is legal. Operands are latched at accept, so there is no read/write hazard.

Test Plan:
- ADD: r1=5, r2=7, opcode 0x2058 (dreg1, ADD, sreg2) -> aluGo one cycle at T+1; wrEn at T+3 with wrAddr=1, wrData=12; carryF=0, zeroF=0; done once.
- ADD overflow: r1=0xFFFFFFFF, r2=1, opcode 0x2058 -> wrData=0, carryF=1, zeroF=1.
- SHR unary: r4=0x3, opcode 0x6D98 (dreg3, OPS_SHR, sreg4) -> wrAddr=3, wrData=1, carryF=1; aluSubOp/aluRite held stable in CAPTURE.
- CMP: r1=r2=9, opcode with subOp=OPS_CMP -> no wrEn; zeroF=1, done=1.
- Illegal: opcode 0x2059, then a subOp[4]=1 opcode -> errPulse and done each, no aluGo, flags unchanged, opReady stays 1.
- Reset mid-op: assert rsta asynchronously during CAPTURE -> all outputs 0 immediately, no wrEn/done; the next op after reset completes normally. Also offer a second opValid during ISSUE -> ignored.
